// File: rtl/snd_stream_sched_if.sv
// Command, beat-strobe and burst-address bundle between the sound player
// control and the per-channel playback scheduler.
interface snd_stream_sched_if #(
    parameter int NCH = 5
);
    logic [NCH-1:0]    CH_PLAY;
    logic [NCH-1:0]    CH_STOP;
    logic [NCH-1:0]    CH_LOOP;
    logic [NCH*32-1:0] CH_START;
    logic [NCH*16-1:0] CH_NBURST;
    logic [NCH-1:0]    CH_BEAT;
    logic [NCH*32-1:0] CH_ADDR;
    logic [NCH*8-1:0]  CH_LEN;
    logic [NCH-1:0]    CH_BUSY;
    logic [NCH-1:0]    CH_DONE;
    logic [NCH*16-1:0] CH_POS;

    modport master (
        output CH_PLAY, CH_STOP, CH_LOOP, CH_START, CH_NBURST, CH_BEAT,
        input  CH_ADDR, CH_LEN, CH_BUSY, CH_DONE, CH_POS
    );

    modport slave (
        input  CH_PLAY, CH_STOP, CH_LOOP, CH_START, CH_NBURST, CH_BEAT,
        output CH_ADDR, CH_LEN, CH_BUSY, CH_DONE, CH_POS
    );
endinterface

// File: rtl/snd_stream_sched.sv
// Per-channel sound VRAM burst scheduler: walks each sound burst by burst and
// parks idle channels on a zero-filled silence buffer.
module snd_stream_sched #(
    parameter int          NCH          = 5,
    parameter int          BURST_BEATS  = 32,
    parameter logic [31:0] SILENCE_ADDR = 32'h1FF0_0000
) (
    input logic               ACLK,
    input logic               ARST,
    snd_stream_sched_if.slave bus
);
    localparam int              BC_W        = $clog2(BURST_BEATS);
    localparam logic [BC_W-1:0] BC_LAST     = BC_W'(BURST_BEATS - 1);
    localparam logic [31:0]     BURST_BYTES = 32'(BURST_BEATS * 4);
    localparam logic [31:0]     ALIGN_MASK  = ~(BURST_BYTES - 32'd1);
    localparam logic [7:0]      BURST_LEN   = 8'(BURST_BEATS - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t          r_state     [NCH];
    logic [BC_W-1:0] r_bc        [NCH];
    logic [31:0]     r_addr      [NCH];
    logic [15:0]     r_pos       [NCH];
    logic [31:0]     r_sh_start  [NCH];
    logic [15:0]     r_sh_nburst [NCH];
    logic [31:0]     r_cur_start [NCH];
    logic [15:0]     r_cur_nburst[NCH];
    logic [NCH-1:0]  r_busy;
    logic [NCH-1:0]  r_done;
    logic [NCH-1:0]  r_pend_play;
    logic [NCH-1:0]  r_pend_stop;

    logic [NCH*32-1:0] w_addr;
    logic [NCH*16-1:0] w_pos;
    logic [NCH*8-1:0]  w_len;

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (ARST) begin
                r_state[i]      <= S_IDLE;
                r_bc[i]         <= '0;
                r_addr[i]       <= SILENCE_ADDR;
                r_pos[i]        <= '0;
                r_sh_start[i]   <= '0;
                r_sh_nburst[i]  <= '0;
                r_cur_start[i]  <= '0;
                r_cur_nburst[i] <= '0;
                r_busy[i]       <= 1'b0;
                r_done[i]       <= 1'b0;
                r_pend_play[i]  <= 1'b0;
                r_pend_stop[i]  <= 1'b0;
            end else begin
                r_done[i] <= 1'b0;
                if (bus.CH_BEAT[i])
                    r_bc[i] <= r_bc[i] + 1'b1;

                // Everything the read controller sees moves only at burst end,
                // so the address is never disturbed under an in-flight burst.
                if (bus.CH_BEAT[i] && (r_bc[i] == BC_LAST)) begin
                    r_pend_play[i] <= 1'b0;
                    r_pend_stop[i] <= 1'b0;
                    if ((r_state[i] == S_PLAY) && r_pend_stop[i]) begin
                        r_state[i] <= S_IDLE;
                        r_addr[i]  <= SILENCE_ADDR;
                        r_pos[i]   <= '0;
                        r_busy[i]  <= 1'b0;
                    end else if (r_pend_play[i] && (r_sh_nburst[i] != 16'd0)) begin
                        r_state[i]      <= S_PLAY;
                        r_addr[i]       <= r_sh_start[i];
                        r_pos[i]        <= '0;
                        r_busy[i]       <= 1'b1;
                        r_cur_start[i]  <= r_sh_start[i];
                        r_cur_nburst[i] <= r_sh_nburst[i];
                    end else if (r_state[i] == S_PLAY) begin
                        if (({1'b0, r_pos[i]} + 17'd1) < {1'b0, r_cur_nburst[i]}) begin
                            r_pos[i]  <= r_pos[i] + 16'd1;
                            r_addr[i] <= r_addr[i] + BURST_BYTES;
                        end else if (bus.CH_LOOP[i]) begin
                            r_pos[i]  <= '0;
                            r_addr[i] <= r_cur_start[i];
                        end else begin
                            r_state[i] <= S_IDLE;
                            r_addr[i]  <= SILENCE_ADDR;
                            r_pos[i]   <= '0;
                            r_busy[i]  <= 1'b0;
                            r_done[i]  <= 1'b1;
                        end
                    end
                end

                // Commands landing on the burst-end cycle wait for the next one.
                if (bus.CH_STOP[i] && bus.CH_PLAY[i]) begin
                    r_pend_stop[i] <= 1'b1;
                    r_pend_play[i] <= 1'b0;
                end else if (bus.CH_STOP[i]) begin
                    r_pend_stop[i] <= 1'b1;
                end else if (bus.CH_PLAY[i]) begin
                    r_pend_play[i] <= 1'b1;
                    r_sh_start[i]  <= bus.CH_START[32*i +: 32] & ALIGN_MASK;
                    r_sh_nburst[i] <= bus.CH_NBURST[16*i +: 16];
                end
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_pos  = '0;
        w_len  = '0;
        for (int i = 0; i < NCH; i++) begin
            w_addr[32*i +: 32] = r_addr[i];
            w_pos[16*i +: 16]  = r_pos[i];
            w_len[8*i +: 8]    = BURST_LEN;
        end
    end

    assign bus.CH_ADDR = w_addr;
    assign bus.CH_POS  = w_pos;
    assign bus.CH_LEN  = w_len;
    assign bus.CH_BUSY = r_busy;
    assign bus.CH_DONE = r_done;
endmodule
